// File: rtl/envelope_sequencer.sv
// ============================================================================
// Module      : envelope_sequencer
// Description : NRx2/NRx4 decode and frame-tick divider feeding a channel's
//               volume envelope (trigger, latched fields, env_step enable).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module envelope_sequencer #(
    parameter int STEP_BITS      = 3,
    parameter int ENV_FRAME_STEP = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       nrx2_wr,
    input  logic [7:0] nrx2_data,
    input  logic       trig_wr,
    output logic       trigger,
    output logic [3:0] starting_volume,
    output logic       envelope_add,
    output logic [2:0] period,
    output logic       env_step,
    output logic       dac_enable,
    output logic       channel_on
);

    localparam logic [STEP_BITS-1:0] c_env_frame_step = STEP_BITS'(ENV_FRAME_STEP);
    localparam logic [3:0]           c_full_period    = 4'd8;

    logic [7:0]           r_shadow;
    logic [STEP_BITS-1:0] r_step;
    logic [3:0]           r_timer;
    logic                 r_trigger;
    logic [3:0]           r_starting_volume;
    logic                 r_envelope_add;
    logic [2:0]           r_period;
    logic                 r_env_step;
    logic                 r_channel_on;

    logic [7:0] w_eff;
    logic       w_eff_dac;
    logic       w_env_clk;
    logic       w_accept;
    logic       w_channel_on_nxt;
    logic [3:0] w_load_period;

    // A write in the same cycle as a trigger is the value the trigger sees.
    assign w_eff         = nrx2_wr ? nrx2_data : r_shadow;
    assign w_eff_dac     = |w_eff[7:3];
    assign w_env_clk     = frame_tick && (r_step == c_env_frame_step);
    assign w_accept      = trig_wr && w_eff_dac;
    assign w_load_period = (w_eff[2:0] == 3'd0) ? c_full_period : {1'b0, w_eff[2:0]};

    always_comb begin
        w_channel_on_nxt = r_channel_on;
        if (w_accept) begin
            w_channel_on_nxt = 1'b1;
        end else if (trig_wr) begin
            w_channel_on_nxt = 1'b0;
        end else if (nrx2_wr && (nrx2_data[7:3] == 5'd0)) begin
            w_channel_on_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow          <= 8'd0;
            r_step            <= '0;
            r_timer           <= 4'd0;
            r_trigger         <= 1'b0;
            r_starting_volume <= 4'd0;
            r_envelope_add    <= 1'b0;
            r_period          <= 3'd0;
            r_env_step        <= 1'b0;
            r_channel_on      <= 1'b0;
        end else begin
            r_trigger    <= w_accept;
            r_env_step   <= 1'b0;
            r_channel_on <= w_channel_on_nxt;

            if (nrx2_wr) begin
                r_shadow <= nrx2_data;
            end
            if (frame_tick) begin
                r_step <= r_step + 1'b1;
            end

            // An accepted trigger takes priority over a coincident env_clk.
            if (w_accept) begin
                r_starting_volume <= w_eff[7:4];
                r_envelope_add    <= w_eff[3];
                r_period          <= w_eff[2:0];
                r_timer           <= w_load_period;
            end else if (w_env_clk) begin
                if (r_period == 3'd0) begin
                    r_timer <= c_full_period;
                end else if (r_timer == 4'd1) begin
                    r_timer    <= {1'b0, r_period};
                    r_env_step <= w_channel_on_nxt;
                end else begin
                    r_timer <= r_timer - 4'd1;
                end
            end
        end
    end

    assign trigger         = r_trigger;
    assign starting_volume = r_starting_volume;
    assign envelope_add    = r_envelope_add;
    assign period          = r_period;
    assign env_step        = r_env_step;
    assign channel_on      = r_channel_on;
    assign dac_enable      = |r_shadow[7:3];

endmodule

`default_nettype wire

// File: tb/tb_envelope_sequencer.sv
// ============================================================================
// Module      : tb_envelope_sequencer
// Description : Scoreboard bench for envelope_sequencer against a count-based
//               reference model with directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_envelope_sequencer;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       nrx2_wr;
    logic [7:0] nrx2_data;
    logic       trig_wr;
    logic       trigger;
    logic [3:0] starting_volume;
    logic       envelope_add;
    logic [2:0] period;
    logic       env_step;
    logic       dac_enable;
    logic       channel_on;

    envelope_sequencer #(.STEP_BITS(3), .ENV_FRAME_STEP(7)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .nrx2_wr         (nrx2_wr),
        .nrx2_data       (nrx2_data),
        .trig_wr         (trig_wr),
        .trigger         (trigger),
        .starting_volume (starting_volume),
        .envelope_add    (envelope_add),
        .period          (period),
        .env_step        (env_step),
        .dac_enable      (dac_enable),
        .channel_on      (channel_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       trig;
        logic [3:0] sv;
        logic       add;
        logic [2:0] per;
        logic       es;
        logic       dac;
        logic       chon;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   es_seen = 0;
    int   trig_seen = 0;

    // Reference model: whole-frame tick count and env_clks elapsed since reload.
    int m_shadow, m_ticks, m_elapsed, m_sv, m_add, m_per, m_chon;
    bit m_trig, m_es;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_step(input bit rst, input bit ft, input bit w,
                              input int d, input bit tw);
        int  eff;
        bit  env_clk;
        bit  acc;
        if (!rst) begin
            m_shadow = 0; m_ticks = 0; m_elapsed = 0; m_sv = 0; m_add = 0;
            m_per = 0; m_chon = 0; m_trig = 0; m_es = 0;
            return;
        end
        eff     = w ? d : m_shadow;
        env_clk = ft && (m_ticks % 8 == 7);
        acc     = tw && ((eff / 8) != 0);
        m_trig  = acc;
        m_es    = 0;
        if (acc) m_chon = 1;
        else if (tw) m_chon = 0;
        else if (w && (d / 8) == 0) m_chon = 0;
        if (acc) begin
            m_sv = eff / 16; m_add = (eff / 8) % 2; m_per = eff % 8; m_elapsed = 0;
        end else if (env_clk && m_per != 0) begin
            m_elapsed++;
            if (m_elapsed >= m_per) begin
                m_elapsed = 0;
                m_es = (m_chon != 0);
            end
        end
        if (w) m_shadow = d;
        if (ft) m_ticks++;
    endtask

    task automatic cyc(input bit rst, input bit ft, input bit w,
                       input logic [7:0] d, input bit tw);
        exp_t e;
        rst_n = rst; frame_tick = ft; nrx2_wr = w; nrx2_data = d; trig_wr = tw;
        model_step(rst, ft, w, int'(d), tw);
        e.trig = m_trig; e.sv = 4'(m_sv); e.add = m_add[0]; e.per = 3'(m_per);
        e.es = m_es; e.dac = ((m_shadow / 8) != 0); e.chon = m_chon[0];
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        frame_tick = 1'b0; nrx2_wr = 1'b0; trig_wr = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 1, 0, 8'h00, 0);
            cyc(1, 0, 0, 8'h00, 0);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a = {trigger, starting_volume, envelope_add, period, env_step,
                 dac_enable, channel_on};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t actual trig=%b sv=%h add=%b per=%0d es=%b dac=%b on=%b required trig=%b sv=%h add=%b per=%0d es=%b dac=%b on=%b",
                         $time, a.trig, a.sv, a.add, a.per, a.es, a.dac, a.chon,
                         e.trig, e.sv, e.add, e.per, e.es, e.dac, e.chon);
            end
            if (env_step) es_seen++;
            if (trigger) trig_seen++;
        end
    end

    initial begin
        int es0;
        int tr0;
        rst_n = 1'b0; frame_tick = 1'b0; nrx2_wr = 1'b0; nrx2_data = 8'h00; trig_wr = 1'b0;

        // Reset held while strobes arrive
        for (int i = 0; i < 6; i++) cyc(0, i[0], 1, 8'hF1, 1);
        cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);
        check("reset_trigger_count", trig_seen, 0);

        // 0xA3: one env_step per three env_clks
        cyc(1, 0, 1, 8'hA3, 0);
        tr0 = trig_seen; es0 = es_seen;
        cyc(1, 0, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 0);
        check("a3_trigger", trig_seen - tr0, 1);
        check("a3_volume", int'(starting_volume), 10);
        check("a3_period", int'(period), 3);
        ticks(16);
        check("a3_no_step_16", es_seen - es0, 0);
        ticks(8);
        cyc(1, 0, 0, 8'h00, 0);
        check("a3_step_24", es_seen - es0, 1);
        ticks(24);
        cyc(1, 0, 0, 8'h00, 0);
        check("a3_step_48", es_seen - es0, 2);

        // 0x05: DAC off, trigger refused
        tr0 = trig_seen;
        cyc(1, 0, 1, 8'h05, 0);
        cyc(1, 0, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 0);
        check("dacoff_no_trigger", trig_seen - tr0, 0);
        check("dacoff_channel_on", int'(channel_on), 0);
        es0 = es_seen;
        ticks(32);
        check("dacoff_no_step", es_seen - es0, 0);

        // 0xF8 written together with trigger
        tr0 = trig_seen;
        cyc(1, 0, 1, 8'hF8, 1);
        cyc(1, 0, 0, 8'h00, 0);
        check("f8_trigger", trig_seen - tr0, 1);
        check("f8_volume", int'(starting_volume), 15);
        check("f8_add", int'(envelope_add), 1);
        es0 = es_seen;
        ticks(64);
        check("f8_no_step", es_seen - es0, 0);

        // NRx2 rewrite without retrigger keeps latched fields
        cyc(1, 0, 1, 8'h91, 1);
        cyc(1, 0, 1, 8'h47, 0);
        cyc(1, 0, 0, 8'h00, 0);
        check("rewrite_held", {starting_volume, envelope_add, period}, 8'h91);
        cyc(1, 0, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 0);
        check("rewrite_retrig", {starting_volume, envelope_add, period}, 8'h47);

        // Trigger coincident with an expiring env_clk (period 1)
        cyc(0, 0, 0, 8'h00, 0);
        cyc(1, 0, 1, 8'h81, 0);
        cyc(1, 0, 0, 8'h00, 1);
        ticks(7);
        es0 = es_seen; tr0 = trig_seen;
        cyc(1, 1, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 0);
        check("coincide_trigger", trig_seen - tr0, 1);
        check("coincide_no_step", es_seen - es0, 0);
        ticks(8);
        check("coincide_restart", es_seen - es0, 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d[7:3] = 5'd0;
            if ($urandom_range(0, 1) == 0) d[2] = 1'b0;
            cyc($urandom_range(0, 499) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 39) == 0, d, $urandom_range(0, 149) == 0);
        end

        cyc(1, 0, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
